conv_punct_encoder: RTL

- Parametrised IEEE 802.11 convolutional encoder with rate-dependent puncturing and an output bit gearbox, on AXI4-Stream.
- The puncture phase and encoder history carry across input beats. The rate is latched per packet.
- Coded bits are packed into fixed-width output words; the last, partial word is flagged with a valid-bit count.
- Sits between the scrambler and the interleaver in the TX chain.

---
 rtl/conv_punct_encoder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_punct_encoder.sv
// 802.11 convolutional encoder (K=7, 133/171) with per-packet puncturing and an output bit gearbox.
// Optional tail-bit flush after the last beat: define CONV_TAIL_FLUSH_EN.
`ifndef RATE_6M
`define RATE_6M  4'b1011
`endif
`ifndef RATE_9M
`define RATE_9M  4'b1111
`endif
`ifndef RATE_12M
`define RATE_12M 4'b1010
`endif
`ifndef RATE_18M
`define RATE_18M 4'b1110
`endif
`ifndef RATE_24M
`define RATE_24M 4'b1001
`endif
`ifndef RATE_36M
`define RATE_36M 4'b1101
`endif
`ifndef RATE_48M
`define RATE_48M 4'b1000
`endif
`ifndef RATE_54M
`define RATE_54M 4'b1100
`endif

module conv_punct_encoder #(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 48,
  parameter int unsigned K         = 7,
  parameter logic [K-1:0] G0       = 7'o133,
  parameter logic [K-1:0] G1       = 7'o171
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [IN_WIDTH-1:0]            s_axis_tdata,
  input  logic [3:0]                     s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [OUT_WIDTH-1:0]           m_axis_tdata,
  output logic [3:0]                     m_axis_tuser,
  output logic [$clog2(OUT_WIDTH+1)-1:0] m_axis_tcount,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam int unsigned CW    = $clog2(OUT_WIDTH + 1);
  localparam int unsigned PW    = 2 * IN_WIDTH;
  localparam int unsigned PCW   = $clog2(PW + 1);
  localparam int unsigned ACC_W = OUT_WIDTH + PW;
  localparam int unsigned ACW   = $clog2(ACC_W + 1);
  localparam int unsigned HW    = K - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DRAIN} state_t;

`ifdef CONV_TAIL_FLUSH_EN
  localparam state_t S_END = S_TAIL;
`else
  localparam state_t S_END = S_DRAIN;
`endif

  state_t            state;
  logic [3:0]        rate_q;
  logic [HW-1:0]     hist_q;
  logic [1:0]        phase_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACW-1:0]    acc_cnt_q;

  logic              space_c, in_hs, tail_push, last_push, push;
  logic              first_c, tail_c;
  logic [3:0]        rate_c;
  logic [PW-1:0]     pbits;
  logic [PCW-1:0]    pcnt;
  logic [HW-1:0]     hist_n;
  logic [1:0]        phase_n;
  logic [ACC_W-1:0]  sum_c, rem_data;
  logic [ACW-1:0]    cnt_sum, rem_cnt;
  logic              full_c;

  // Puncture pattern length in input bits for a rate code.
  function automatic logic [1:0] plen_f(input logic [3:0] r);
    case (r)
      `RATE_9M, `RATE_18M, `RATE_36M, `RATE_54M: plen_f = 2'd3;
      `RATE_48M:                                 plen_f = 2'd2;
      default:                                   plen_f = 2'd1;
    endcase
  endfunction

  assign space_c       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !areset && (state == S_IDLE || state == S_RUN) && space_c;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign push          = in_hs || tail_push;
  assign first_c       = (state == S_IDLE);
  assign tail_c        = (state == S_TAIL);
  assign rate_c        = first_c ? s_axis_tuser : rate_q;

`ifdef CONV_TAIL_FLUSH_EN
  assign tail_push = tail_c && space_c;
  assign last_push = tail_push;
`else
  assign tail_push = 1'b0;
  assign last_push = in_hs && s_axis_tlast;
`endif

  // Encode and puncture one beat (or K-1 zero tail bits) into a packed bit run.
  always_comb begin
    logic [HW-1:0] h;
    logic [1:0]    ph;
    logic [1:0]    plen;
    logic [K-1:0]  w;
    logic          bit_in, a, b, keep_a, keep_b;
    pbits  = '0;
    pcnt   = '0;
    h      = first_c ? '0 : hist_q;
    ph     = first_c ? 2'd0 : phase_q;
    plen   = plen_f(rate_c);
    w      = '0;
    bit_in = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    keep_a = 1'b0;
    keep_b = 1'b0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (!tail_c || i < HW) begin
        bit_in = tail_c ? 1'b0 : s_axis_tdata[i];
        w      = {bit_in, h};
        a      = ^(w & G0);
        b      = ^(w & G1);
        keep_a = !(plen == 2'd3 && ph == 2'd2);
        keep_b = !(plen != 2'd1 && ph == 2'd1);
        if (keep_a) begin
          pbits[pcnt] = a;
          pcnt        = pcnt + PCW'(1);
        end
        if (keep_b) begin
          pbits[pcnt] = b;
          pcnt        = pcnt + PCW'(1);
        end
        h  = {bit_in, h[HW-1:1]};
        ph = (ph == plen - 2'd1) ? 2'd0 : ph + 2'd1;
      end
    end
    hist_n  = h;
    phase_n = ph;
  end

  // Gearbox: append the new run and split off one full word when available.
  always_comb begin
    sum_c    = acc_q | (ACC_W'(pbits) << acc_cnt_q);
    cnt_sum  = acc_cnt_q + ACW'(pcnt);
    full_c   = cnt_sum >= ACW'(OUT_WIDTH);
    rem_data = full_c ? (sum_c >> OUT_WIDTH) : sum_c;
    rem_cnt  = full_c ? (cnt_sum - ACW'(OUT_WIDTH)) : cnt_sum;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      rate_q        <= '0;
      hist_q        <= '0;
      phase_q       <= '0;
      acc_q         <= '0;
      acc_cnt_q     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tcount <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (push) begin
        hist_q    <= hist_n;
        phase_q   <= phase_n;
        acc_q     <= rem_data;
        acc_cnt_q <= rem_cnt;
        if (full_c) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= sum_c[OUT_WIDTH-1:0];
          m_axis_tcount <= CW'(OUT_WIDTH);
          m_axis_tlast  <= last_push && (rem_cnt == '0);
          m_axis_tuser  <= rate_c;
        end
      end
      case (state)
        S_IDLE: if (in_hs) begin
          rate_q <= s_axis_tuser;
          state  <= s_axis_tlast ? S_END : S_RUN;
        end
        S_RUN:  if (in_hs && s_axis_tlast) state <= S_END;
        S_TAIL: if (tail_push) state <= S_DRAIN;
        S_DRAIN: if (space_c) begin
          // Partial remainder goes out as the closing word; an empty one is skipped.
          if (acc_cnt_q != '0) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc_q[OUT_WIDTH-1:0];
            m_axis_tcount <= CW'(acc_cnt_q);
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= rate_q;
          end
          acc_q     <= '0;
          acc_cnt_q <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
